id_ex_reg: RTL

ID/EX pipeline register of the five-stage core: captures decoded operands, immediate, register indices and control bits at the end of ID and presents them to EX, the forwarding unit and the EX operand-select muxes. Supports stall (hold), flush (bubble insertion) and an optional write-back bypass that closes the same-cycle register-file write/read hole.

---
 rtl/id_ex_reg_pkg.sv | 38 +++
 rtl/id_ex_bypass.sv | 29 ++
 rtl/id_ex_reg.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// control-bundle bit positions, ALUOp encodings and the per-edge update kind.
package id_ex_reg_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_AW = 5;
  localparam int unsigned DEF_CW = 8;

  // Control bundle layout, MSB first
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_REGDST   = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STALL = 2'b01,
    OP_FLUSH = 2'b10
  } id_ex_op_e;

  // True when a WB write targets a real (non-zero) register equal to src
  function automatic logic wb_hit(input logic we, input logic [DEF_AW-1:0] wb_addr,
                                  input logic [DEF_AW-1:0] src_addr);
    return we && (wb_addr == src_addr) && (wb_addr != {DEF_AW{1'b0}});
  endfunction

endpackage

// File: rtl/id_ex_bypass.sv
// Write-back bypass select: substitutes WB write data when the WB destination
// matches a non-zero source index.
module id_ex_bypass
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic [DW-1:0] sel_data
);

  logic hit_s;

  // Index compare and data select
  always_comb begin
    hit_s = wb_we && (wb_addr == src_addr) && (wb_addr != {AW{1'b0}});
    if (hit_s) begin
      sel_data = wb_data;
    end else begin
      sel_data = src_data;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and valid-gated control bundle.
// Optional write-back bypass (load and hold) enabled by `ID_EX_WB_BYPASS_EN.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] pc_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [CW-1:0] ctrl_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          valid_o,
  output logic [DW-1:0] pc_o,
  output logic [DW-1:0] rs_data_o,
  output logic [DW-1:0] rt_data_o,
  output logic [DW-1:0] imm_o,
  output logic [AW-1:0] rs_addr_o,
  output logic [AW-1:0] rt_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic [CW-1:0] ctrl_o
);

  id_ex_op_e     op_s;

  logic          valid_r,   valid_n_s;
  logic [DW-1:0] pc_r,      pc_n_s;
  logic [DW-1:0] rs_data_r, rs_data_n_s;
  logic [DW-1:0] rt_data_r, rt_data_n_s;
  logic [DW-1:0] imm_r,     imm_n_s;
  logic [AW-1:0] rs_addr_r, rs_addr_n_s;
  logic [AW-1:0] rt_addr_r, rt_addr_n_s;
  logic [AW-1:0] rd_addr_r, rd_addr_n_s;
  logic [CW-1:0] ctrl_r,    ctrl_n_s;

  // Operand data after optional WB substitution; source depends on load vs hold
  logic [DW-1:0] rs_fwd_s;
  logic [DW-1:0] rt_fwd_s;

  // Update kind for this edge: flush beats stall beats load
  always_comb begin
    op_s = OP_LOAD;
    if (flush_i) begin
      op_s = OP_FLUSH;
    end else if (stall_i) begin
      op_s = OP_STALL;
    end else begin
      op_s = OP_LOAD;
    end
  end

`ifdef ID_EX_WB_BYPASS_EN
  logic [AW-1:0] rs_src_addr_s;
  logic [AW-1:0] rt_src_addr_s;
  logic [DW-1:0] rs_src_data_s;
  logic [DW-1:0] rt_src_data_s;

  // On hold the bypass watches the held indices, otherwise the incoming ones
  always_comb begin
    if (op_s == OP_STALL) begin
      rs_src_addr_s = rs_addr_r;
      rt_src_addr_s = rt_addr_r;
      rs_src_data_s = rs_data_r;
      rt_src_data_s = rt_data_r;
    end else begin
      rs_src_addr_s = rs_addr_i;
      rt_src_addr_s = rt_addr_i;
      rs_src_data_s = rs_data_i;
      rt_src_data_s = rt_data_i;
    end
  end

  id_ex_bypass #(.DW(DW), .AW(AW)) u_rs_bypass (
    .wb_we    (wb_we_i),
    .wb_addr  (wb_addr_i),
    .wb_data  (wb_data_i),
    .src_addr (rs_src_addr_s),
    .src_data (rs_src_data_s),
    .sel_data (rs_fwd_s)
  );

  id_ex_bypass #(.DW(DW), .AW(AW)) u_rt_bypass (
    .wb_we    (wb_we_i),
    .wb_addr  (wb_addr_i),
    .wb_data  (wb_data_i),
    .src_addr (rt_src_addr_s),
    .src_data (rt_src_data_s),
    .sel_data (rt_fwd_s)
  );
`else
  // Register file already does write-before-read; WB ports are inert here
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_we_i, wb_addr_i, wb_data_i};

  // Operand data comes straight from the inputs or is held verbatim
  always_comb begin
    if (op_s == OP_STALL) begin
      rs_fwd_s = rs_data_r;
      rt_fwd_s = rt_data_r;
    end else begin
      rs_fwd_s = rs_data_i;
      rt_fwd_s = rt_data_i;
    end
  end
`endif

  // Next-state selection for every field
  always_comb begin
    valid_n_s   = 1'b0;
    pc_n_s      = {DW{1'b0}};
    rs_data_n_s = {DW{1'b0}};
    rt_data_n_s = {DW{1'b0}};
    imm_n_s     = {DW{1'b0}};
    rs_addr_n_s = {AW{1'b0}};
    rt_addr_n_s = {AW{1'b0}};
    rd_addr_n_s = {AW{1'b0}};
    ctrl_n_s    = {CW{1'b0}};
    case (op_s)
      OP_FLUSH: begin
        valid_n_s = 1'b0;
      end
      OP_STALL: begin
        valid_n_s   = valid_r;
        pc_n_s      = pc_r;
        rs_data_n_s = rs_fwd_s;
        rt_data_n_s = rt_fwd_s;
        imm_n_s     = imm_r;
        rs_addr_n_s = rs_addr_r;
        rt_addr_n_s = rt_addr_r;
        rd_addr_n_s = rd_addr_r;
        ctrl_n_s    = ctrl_r;
      end
      OP_LOAD: begin
        valid_n_s   = valid_i;
        pc_n_s      = pc_i;
        rs_data_n_s = rs_fwd_s;
        rt_data_n_s = rt_fwd_s;
        imm_n_s     = imm_i;
        rs_addr_n_s = rs_addr_i;
        rt_addr_n_s = rt_addr_i;
        rd_addr_n_s = rd_addr_i;
        // A bubble never carries control, whatever decode produced
        ctrl_n_s    = ctrl_i & {CW{valid_i}};
      end
      default: begin
        valid_n_s = 1'b0;
      end
    endcase
  end

  // Pipeline register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_r   <= 1'b0;
      pc_r      <= {DW{1'b0}};
      rs_data_r <= {DW{1'b0}};
      rt_data_r <= {DW{1'b0}};
      imm_r     <= {DW{1'b0}};
      rs_addr_r <= {AW{1'b0}};
      rt_addr_r <= {AW{1'b0}};
      rd_addr_r <= {AW{1'b0}};
      ctrl_r    <= {CW{1'b0}};
    end else begin
      valid_r   <= valid_n_s;
      pc_r      <= pc_n_s;
      rs_data_r <= rs_data_n_s;
      rt_data_r <= rt_data_n_s;
      imm_r     <= imm_n_s;
      rs_addr_r <= rs_addr_n_s;
      rt_addr_r <= rt_addr_n_s;
      rd_addr_r <= rd_addr_n_s;
      ctrl_r    <= ctrl_n_s;
    end
  end

  assign valid_o   = valid_r;
  assign pc_o      = pc_r;
  assign rs_data_o = rs_data_r;
  assign rt_data_o = rt_data_r;
  assign imm_o     = imm_r;
  assign rs_addr_o = rs_addr_r;
  assign rt_addr_o = rt_addr_r;
  assign rd_addr_o = rd_addr_r;
  assign ctrl_o    = ctrl_r;

endmodule
